digit_serial_adder: RTL and testbench

Sequential, parametrised successor to the combinational full adder. Adds or subtracts two WORD_WIDTH operands DIGIT_WIDTH bits per cycle, holding the inter-digit carry in a register. This trades latency for a narrow adder, with no reliance on FPGA carry-chain logic beyond one digit. It sits between an operand source and a result consumer, with ready/valid handshakes on both sides.

---
 rtl/digit_serial_adder.sv | 107 ++++++++++
 tb/tb_digit_serial_adder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: adds two WORD_WIDTH operands DIGIT_WIDTH bits per cycle,
// carrying between digits in a register, with ready/valid handshakes on both sides.
module digit_serial_adder #(
  parameter int unsigned WORD_WIDTH  = 8,
  parameter int unsigned DIGIT_WIDTH = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  sub,
  input  logic                  carry_in,
  input  logic [WORD_WIDTH-1:0] A,
  input  logic [WORD_WIDTH-1:0] B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] sum,
  output logic                  carry_out,
  output logic                  overflow
);

  localparam int unsigned N   = WORD_WIDTH / DIGIT_WIDTH;
  localparam int unsigned CW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DW1 = DIGIT_WIDTH + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                  state, state_next;
  logic [WORD_WIDTH-1:0]   a_reg, b_reg;
  logic [WORD_WIDTH-1:0]   a_shift, b_shift, sum_shift;
  logic                    carry_reg;
  logic [CW-1:0]           count;
  logic [DIGIT_WIDTH:0]    digit_sum;
  logic                    msb_carry;
  logic                    accept;
  logic                    last_digit;

  // in_ready depends only on state and out_ready, so a DONE handshake can overlap the next accept
  assign in_ready   = (state == S_IDLE) | ((state == S_DONE) & out_ready);
  assign accept     = in_valid & in_ready;
  assign out_valid  = (state == S_DONE);
  assign last_digit = (state == S_RUN) && (count == LAST);

  assign digit_sum = {1'b0, a_reg[DIGIT_WIDTH-1:0]} + {1'b0, b_reg[DIGIT_WIDTH-1:0]}
                   + DW1'(carry_reg);
  // Carry into the digit's top bit recovered from its operand bits and sum bit
  assign msb_carry = a_reg[DIGIT_WIDTH-1] ^ b_reg[DIGIT_WIDTH-1] ^ digit_sum[DIGIT_WIDTH-1];

  generate
    if (N == 1) begin : g_single
      assign a_shift   = '0;
      assign b_shift   = '0;
      assign sum_shift = digit_sum[DIGIT_WIDTH-1:0];
    end else begin : g_multi
      assign a_shift   = {DIGIT_WIDTH'(0), a_reg[WORD_WIDTH-1:DIGIT_WIDTH]};
      assign b_shift   = {DIGIT_WIDTH'(0), b_reg[WORD_WIDTH-1:DIGIT_WIDTH]};
      assign sum_shift = {digit_sum[DIGIT_WIDTH-1:0], sum[WORD_WIDTH-1:DIGIT_WIDTH]};
    end
  endgenerate

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (in_valid)   state_next = S_RUN;
      S_RUN:  if (last_digit) state_next = S_DONE;
      S_DONE: if (out_ready)  state_next = in_valid ? S_RUN : S_IDLE;
      default:                state_next = S_IDLE;
    endcase
  end

  // Operand capture and per-digit datapath
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      count     <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      a_reg     <= A;
      b_reg     <= sub ? ~B : B;
      carry_reg <= carry_in;
      count     <= '0;
    end else if (state == S_RUN) begin
      a_reg     <= a_shift;
      b_reg     <= b_shift;
      sum       <= sum_shift;
      carry_reg <= digit_sum[DIGIT_WIDTH];
      count     <= last_digit ? '0 : count + CW'(1);
      if (last_digit) begin
        carry_out <= digit_sum[DIGIT_WIDTH];
        overflow  <= msb_carry ^ digit_sum[DIGIT_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder: an 8/2 instance (N=4) and an 8/8 instance (N=1).
module tb_digit_serial_adder;

  typedef struct {
    logic [7:0] sum;
    logic       co;
    logic       ov;
    int         due;
  } exp_t;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  int         cycle = 0;
  int         checks = 0;
  int         failures = 0;

  logic       iv0 = 0, sub0 = 0, cin0 = 0, or0 = 1;
  logic [7:0] a0 = 0, b0 = 0;
  logic       rdy0, vld0, co0, ovf0;
  logic [7:0] sum0;

  logic       iv1 = 0, sub1 = 0, cin1 = 0, or1 = 1;
  logic [7:0] a1 = 0, b1 = 0;
  logic       rdy1, vld1, co1, ovf1;
  logic [7:0] sum1;

  exp_t q0[$];
  exp_t q1[$];
  int   vs0 = 0, vs1 = 0;
  logic prev0 = 0, prev1 = 0;
  int   last_acc0 = 0;

  digit_serial_adder #(.WORD_WIDTH(8), .DIGIT_WIDTH(2)) dut0 (
    .clock(clock), .reset_n(rst_n), .in_valid(iv0), .in_ready(rdy0), .sub(sub0),
    .carry_in(cin0), .A(a0), .B(b0), .out_valid(vld0), .out_ready(or0),
    .sum(sum0), .carry_out(co0), .overflow(ovf0)
  );

  digit_serial_adder #(.WORD_WIDTH(8), .DIGIT_WIDTH(8)) dut1 (
    .clock(clock), .reset_n(rst_n), .in_valid(iv1), .in_ready(rdy1), .sub(sub1),
    .carry_in(cin1), .A(a1), .B(b1), .out_valid(vld1), .out_ready(or1),
    .sum(sum1), .carry_out(co1), .overflow(ovf1)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_result(input string tag, input exp_t e, input logic [7:0] s,
                              input logic co, input logic ov, input int vs);
    chk({tag, "_latency"}, vs, e.due);
    chk({tag, "_sum"}, {24'd0, s}, {24'd0, e.sum});
    chk({tag, "_carry_out"}, {31'd0, co}, {31'd0, e.co});
    chk({tag, "_overflow"}, {31'd0, ov}, {31'd0, e.ov});
  endtask

  // Monitors: pop and compare on each output handshake
  always @(negedge clock) begin
    if (rst_n) begin
      if (vld0 && !prev0) vs0 = cycle;
      if (vld0 && or0) begin
        if (q0.size() == 0) chk("dut0_unexpected_result", 1, 0);
        else check_result("dut0", q0.pop_front(), sum0, co0, ovf0, vs0);
      end
    end
    prev0 = rst_n && vld0;
  end

  always @(negedge clock) begin
    if (rst_n) begin
      if (vld1 && !prev1) vs1 = cycle;
      if (vld1 && or1) begin
        if (q1.size() == 0) chk("dut1_unexpected_result", 1, 0);
        else check_result("dut1", q1.pop_front(), sum1, co1, ovf1, vs1);
      end
    end
    prev1 = rst_n && vld1;
  end

  // Called at posedge+1; returns at posedge+1 of the accept edge
  task automatic send(input int u, input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic ci, input logic [7:0] es, input logic eco, input logic eov,
                      input logic hold);
    int n;
    exp_t e;
    if (u == 0) begin a0 = a; b0 = b; sub0 = s; cin0 = ci; iv0 = 1; end
    else        begin a1 = a; b1 = b; sub1 = s; cin1 = ci; iv1 = 1; end
    @(negedge clock);
    n = 0;
    while (!(u == 0 ? rdy0 : rdy1) && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!(u == 0 ? rdy0 : rdy1)) begin
      chk("accept_timeout", 0, 1);
      iv0 = 0;
      iv1 = 0;
    end else begin
      @(posedge clock);
      #1;
      e.sum = es; e.co = eco; e.ov = eov;
      e.due = cycle + ((u == 0) ? 4 : 1);
      if (u == 0) begin q0.push_back(e); last_acc0 = cycle; end
      else q1.push_back(e);
      if (!hold) begin
        if (u == 0) iv0 = 0;
        else iv1 = 0;
      end
    end
  endtask

  task automatic wait_drain();
    int n;
    for (n = 0; n < 200 && (q0.size() != 0 || q1.size() != 0); n++) @(negedge clock);
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int k;
    int n;
    #3;
    chk("reset_in_ready0", {31'd0, rdy0}, 1);
    chk("reset_out_valid0", {31'd0, vld0}, 0);
    chk("reset_sum0", {24'd0, sum0}, 0);
    chk("reset_carry_out0", {31'd0, co0}, 0);
    chk("reset_overflow0", {31'd0, ovf0}, 0);
    chk("reset_in_ready1", {31'd0, rdy1}, 1);
    @(posedge clock);
    #3 rst_n = 1;
    @(posedge clock);
    #1;

    // Basic add, subtract and wrap-around
    send(0, 8'h5A, 8'h33, 0, 0, 8'h8D, 0, 1, 0);
    #3 chk("run_in_ready0", {31'd0, rdy0}, 0);
    wait_drain();
    send(0, 8'h10, 8'h20, 1, 1, 8'hF0, 0, 0, 0);
    wait_drain();
    send(0, 8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, 0);
    wait_drain();

    // Backpressure: DONE holds, in_valid pulses ignored, then overlapped accept
    or0 = 0;
    send(0, 8'h12, 8'h34, 0, 0, 8'h46, 0, 0, 0);
    for (n = 0; n < 20 && !vld0; n++) @(negedge clock);
    chk("bp_valid_seen", {31'd0, vld0}, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      iv0 = i[0];
      a0 = 8'hAA;
      b0 = 8'h55;
      @(negedge clock);
      chk("bp_out_valid", {31'd0, vld0}, 1);
      chk("bp_in_ready", {31'd0, rdy0}, 0);
      chk("bp_sum_stable", {24'd0, sum0}, 32'h46);
    end
    @(posedge clock);
    #1;
    iv0 = 0;
    or0 = 1;
    send(0, 8'h01, 8'h02, 0, 0, 8'h03, 0, 0, 0);
    wait_drain();

    // Streaming with in_valid and out_ready held high
    send(0, 8'h0F, 8'h01, 0, 0, 8'h10, 0, 0, 1);
    k = last_acc0;
    send(0, 8'h05, 8'h07, 1, 1, 8'hFE, 0, 0, 1);
    chk("stream_period_1", last_acc0 - k, 5);
    k = last_acc0;
    send(0, 8'h80, 8'hFF, 0, 0, 8'h7F, 1, 1, 0);
    chk("stream_period_2", last_acc0 - k, 5);
    wait_drain();

    // Asynchronous reset mid-operation aborts it
    send(0, 8'h11, 8'h22, 0, 0, 8'h33, 0, 0, 0);
    @(posedge clock);
    @(posedge clock);
    #2 rst_n = 0;
    #1;
    chk("abort_out_valid", {31'd0, vld0}, 0);
    chk("abort_sum", {24'd0, sum0}, 0);
    chk("abort_in_ready", {31'd0, rdy0}, 1);
    q0.delete();
    @(posedge clock);
    #3 rst_n = 1;
    @(posedge clock);
    #1;
    send(0, 8'h7F, 8'h01, 0, 0, 8'h80, 0, 1, 0);
    wait_drain();

    // Single-digit configuration
    send(1, 8'h80, 8'h80, 0, 0, 8'h00, 1, 1, 0);
    wait_drain();
    send(1, 8'h7F, 8'h7F, 0, 1, 8'hFF, 0, 1, 0);
    wait_drain();
    send(1, 8'h03, 8'h05, 1, 1, 8'hFE, 0, 0, 0);
    wait_drain();

    repeat (10) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
